// File: rtl/ceespu_fetch_pkg.sv
// Shared ceespu fetch definitions: address width, instruction width, reset PC
// and the width of a buffered {pc, instr} fetch entry.
package ceespu_fetch_pkg;

    localparam int CEESPU_ADDR_BITS  = 25;
    localparam int CEESPU_INSTR_BITS = 32;
    localparam int CEESPU_FIFO_DEPTH = 2;
    localparam logic [CEESPU_ADDR_BITS-1:0] CEESPU_RESET_PC = 25'h0;

    function automatic int fetch_entry_bits(input int addr_bits);
        return addr_bits + CEESPU_INSTR_BITS;
    endfunction

endpackage

// File: rtl/ceespu_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} fetch entries with flush.
// Flush wins over a same-cycle push; the head is readable combinationally.
module ceespu_fetch_fifo
    import ceespu_fetch_pkg::*;
#(
    parameter int ADDR_BITS = CEESPU_ADDR_BITS,
    parameter int DEPTH     = CEESPU_FIFO_DEPTH
) (
    input  logic                         I_clk,
    input  logic                         I_rst,
    input  logic                         I_push,
    input  logic                         I_pop,
    input  logic                         I_flush,
    input  logic [ADDR_BITS-1:0]         I_push_pc,
    input  logic [CEESPU_INSTR_BITS-1:0] I_push_instr,
    output logic [$clog2(DEPTH):0]       O_count,
    output logic [ADDR_BITS-1:0]         O_head_pc,
    output logic [CEESPU_INSTR_BITS-1:0] O_head_instr,
    output logic                         O_empty
);

    localparam int PTR_BITS   = $clog2(DEPTH);
    localparam int ENTRY_BITS = fetch_entry_bits(ADDR_BITS);

    logic [ENTRY_BITS-1:0] mem_reg [DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr_reg;
    logic [PTR_BITS-1:0]   wr_ptr_reg;
    logic [PTR_BITS:0]     count_reg;
    logic [DEPTH-1:0]      wr_en;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = I_push && !I_flush;
    assign do_pop  = I_pop && (count_reg != '0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_BITS'(gi));
    end

    always_ff @(posedge I_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= {I_push_pc, I_push_instr};
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge I_clk) begin
        if (I_rst || I_flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
            end
            count_reg <= count_reg + {{PTR_BITS{1'b0}}, do_push} - {{PTR_BITS{1'b0}}, do_pop};
        end
    end

    assign {O_head_pc, O_head_instr} = mem_reg[rd_ptr_reg];
    assign O_count = count_reg;
    assign O_empty = (count_reg == '0);

endmodule

// File: rtl/ceespu_fetch.sv
// ceespu instruction fetch: PC generation, icache response matching, redirects.
// Optional performance counters are built when CEESPU_FETCH_PERF_EN is defined.
module ceespu_fetch
    import ceespu_fetch_pkg::*;
#(
    parameter int                   ADDR_BITS  = CEESPU_ADDR_BITS,
    parameter logic [ADDR_BITS-1:0] RESET_PC   = ADDR_BITS'(CEESPU_RESET_PC),
    parameter int                   FIFO_DEPTH = CEESPU_FIFO_DEPTH
) (
    input  logic                         I_clk,
    input  logic                         I_rst,
    output logic [ADDR_BITS-1:0]         O_icache_addr,
    input  logic [CEESPU_INSTR_BITS-1:0] I_icache_data,
    input  logic                         I_icache_valid,
    input  logic                         I_icache_stall,
    input  logic                         I_redirect,
    input  logic [ADDR_BITS-1:0]         I_redirect_pc,
    output logic [CEESPU_INSTR_BITS-1:0] O_instr,
    output logic [ADDR_BITS-1:0]         O_instr_pc,
    output logic                         O_instr_valid,
    input  logic                         I_decode_ready,
    output logic [31:0]                  O_perf_stall_cycles,
    output logic [31:0]                  O_perf_fetched
);

    localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_BITS-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_BITS-1:0] resp_pc_reg, resp_pc_next;
    logic [ADDR_BITS-1:0] redir_pc_reg, redir_pc_next;
    logic                 resp_live_reg, resp_live_next;
    logic                 redir_pend_reg, redir_pend_next;

    logic [CNT_BITS-1:0]          fifo_count;
    logic                         fifo_empty;
    logic [ADDR_BITS-1:0]         head_pc;
    logic [CEESPU_INSTR_BITS-1:0] head_instr;
    logic [CNT_BITS:0]            room;
    logic [ADDR_BITS-1:0]         redirect_aligned;
    logic                         pop, push, accept;

    assign redirect_aligned = I_redirect_pc & ~ADDR_BITS'(3);
    assign pop  = !fifo_empty && I_decode_ready;
    // Entries that will occupy the FIFO once the in-flight response lands.
    assign room = {1'b0, fifo_count} - {{CNT_BITS{1'b0}}, pop} + {{CNT_BITS{1'b0}}, resp_live_reg};
    assign accept = !I_icache_stall && !I_redirect && !redir_pend_reg
                    && (room < (CNT_BITS+1)'(FIFO_DEPTH));
    assign push = resp_live_reg && I_icache_valid && !I_redirect;

    always_comb begin
        fetch_pc_next   = fetch_pc_reg;
        resp_pc_next    = resp_pc_reg;
        resp_live_next  = resp_live_reg;
        redir_pend_next = redir_pend_reg;
        redir_pc_next   = redir_pc_reg;
        if (I_redirect) begin
            resp_live_next = 1'b0;
            if (I_icache_stall) begin
                // The icache still owns the held address; retarget after the miss.
                redir_pend_next = 1'b1;
                redir_pc_next   = redirect_aligned;
            end else begin
                redir_pend_next = 1'b0;
                fetch_pc_next   = redirect_aligned;
            end
        end else if (I_icache_stall) begin
            if (I_icache_valid) begin
                resp_live_next = 1'b0;
            end
        end else if (redir_pend_reg) begin
            // Stall-drop cycle issues the stale held address; its response is ignored.
            resp_live_next  = 1'b0;
            redir_pend_next = 1'b0;
            fetch_pc_next   = redir_pc_reg;
        end else begin
            resp_live_next = accept;
            if (accept) begin
                resp_pc_next  = fetch_pc_reg;
                fetch_pc_next = fetch_pc_reg + ADDR_BITS'(4);
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            fetch_pc_reg   <= RESET_PC;
            resp_pc_reg    <= RESET_PC;
            redir_pc_reg   <= RESET_PC;
            resp_live_reg  <= 1'b0;
            redir_pend_reg <= 1'b0;
        end else begin
            fetch_pc_reg   <= fetch_pc_next;
            resp_pc_reg    <= resp_pc_next;
            redir_pc_reg   <= redir_pc_next;
            resp_live_reg  <= resp_live_next;
            redir_pend_reg <= redir_pend_next;
        end
    end

    ceespu_fetch_fifo #(
        .ADDR_BITS (ADDR_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_push       (push),
        .I_pop        (pop),
        .I_flush      (I_redirect),
        .I_push_pc    (resp_pc_reg),
        .I_push_instr (I_icache_data),
        .O_count      (fifo_count),
        .O_head_pc    (head_pc),
        .O_head_instr (head_instr),
        .O_empty      (fifo_empty)
    );

    assign O_icache_addr = fetch_pc_reg;
    assign O_instr_valid = !fifo_empty;
    assign O_instr       = fifo_empty ? '0 : head_instr;
    assign O_instr_pc    = fifo_empty ? '0 : head_pc;

`ifdef CEESPU_FETCH_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_fetched_reg;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            perf_stall_reg   <= '0;
            perf_fetched_reg <= '0;
        end else begin
            if (I_icache_stall) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (pop) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
        end
    end

    assign O_perf_stall_cycles = perf_stall_reg;
    assign O_perf_fetched      = perf_fetched_reg;
`else
    assign O_perf_stall_cycles = '0;
    assign O_perf_fetched      = '0;
`endif

endmodule

// File: tb/tb_ceespu_fetch.sv
// Randomized scoreboard bench for ceespu_fetch with a behavioural icache and
// a program-order model: decode must see a contiguous PC stream from the last redirect.
`timescale 1ns/1ps
module tb_ceespu_fetch;

    localparam int AB = 25;
    localparam logic [AB-1:0] RST_PC = 25'h0;
`ifdef CEESPU_FETCH_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AB-1:0] icache_addr;
    logic [31:0]   ic_data;
    logic          ic_valid;
    logic          ic_stall;
    logic          redirect;
    logic [AB-1:0] redirect_pc;
    logic [31:0]   instr;
    logic [AB-1:0] instr_pc;
    logic          instr_valid;
    logic          dec_ready;
    logic [31:0]   perf_stall;
    logic [31:0]   perf_fet;

    always #5 clk = ~clk;

    ceespu_fetch dut (
        .I_clk               (clk),
        .I_rst               (rst),
        .O_icache_addr       (icache_addr),
        .I_icache_data       (ic_data),
        .I_icache_valid      (ic_valid),
        .I_icache_stall      (ic_stall),
        .I_redirect          (redirect),
        .I_redirect_pc       (redirect_pc),
        .O_instr             (instr),
        .O_instr_pc          (instr_pc),
        .O_instr_valid       (instr_valid),
        .I_decode_ready      (dec_ready),
        .O_perf_stall_cycles (perf_stall),
        .O_perf_fetched      (perf_fet)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Program memory contents: unique word per address.
    function automatic logic [31:0] imem(input logic [AB-1:0] a);
        return {7'h35, a} ^ 32'h0F0F_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural icache ----------------
    int            miss_pct = 0;
    bit            force_miss = 0;
    logic [AB-1:0] force_addr = '0;
    bit            pend_hit;
    int            stall_left;
    int            crit_in;
    logic [AB-1:0] req_addr;

    initial begin
        ic_valid = 1'b0; ic_stall = 1'b0; ic_data = '0;
        pend_hit = 0; stall_left = 0; crit_in = -1; req_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_hit = 0;
                stall_left = 0;
            end else if (!ic_stall) begin
                req_addr = icache_addr;
                if (force_miss && icache_addr == force_addr) begin
                    force_miss = 0; stall_left = 20; crit_in = 4;
                end else if (int'($urandom_range(0, 99)) < miss_pct) begin
                    stall_left = int'($urandom_range(2, 8));
                    crit_in = int'($urandom_range(0, stall_left - 1));
                end else begin
                    pend_hit = 1;
                end
            end
            @(posedge clk); #1;
            ic_valid = 1'b0; ic_stall = 1'b0; ic_data = $urandom;
            if (pend_hit) begin
                ic_valid = 1'b1; ic_data = imem(req_addr); pend_hit = 0;
            end else if (stall_left > 0) begin
                ic_stall = 1'b1; ic_valid = (crit_in == 0); ic_data = imem(req_addr);
                crit_in--; stall_left--;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int            ev_cyc;
        logic [AB-1:0] target;
    } redir_ev_t;
    redir_ev_t     ev_q[$];
    redir_ev_t     ev;
    logic [AB-1:0] cur_pc = RST_PC;
    int            idle = 0;
    int            chk_empty_cyc = -1;
    int            chk_addr_cyc = -1;
    logic [AB-1:0] chk_addr_val = '0;
    int            stall_m = 0;
    int            fet_m = 0;

    always @(negedge clk) begin
        if (rst) begin
            cur_pc = RST_PC; idle = 0; stall_m = 0; fet_m = 0;
            chk_empty_cyc = -1; chk_addr_cyc = -1;
            ev_q.delete();
        end else begin
            if (cyc % 50 == 0) begin
                check("perf_stall_cycles", perf_stall, PERF_EN ? 32'(stall_m) : 32'd0);
                check("perf_fetched", perf_fet, PERF_EN ? 32'(fet_m) : 32'd0);
            end
            if (instr_valid && dec_ready) begin
                check("instr_pc", 32'(instr_pc), 32'(cur_pc));
                check("instr_word", instr, imem(cur_pc));
                $display("pop   cyc=%0d pc=%h instr=%h", cyc, instr_pc, instr);
                cur_pc = cur_pc + 25'd4;
                idle = 0;
                fet_m++;
            end else begin
                idle++;
            end
            if (idle > 150) begin
                n_cmp++; n_fail++;
                $display("FAIL watchdog: no instruction for %0d cycles, required progress (cycle %0d)", idle, cyc);
                idle = 0;
            end
            if (cyc == chk_empty_cyc) check("valid_after_redirect", 32'(instr_valid), 32'd0);
            if (cyc == chk_addr_cyc) check("addr_after_redirect", 32'(icache_addr), 32'(chk_addr_val));
            if (ic_stall) stall_m++;
            while (ev_q.size() > 0 && ev_q[0].ev_cyc <= cyc) begin
                ev = ev_q.pop_front();
                cur_pc = {ev.target[AB-1:2], 2'b00};
                chk_empty_cyc = cyc + 1;
                if (!ic_stall) begin
                    chk_addr_cyc = cyc + 1;
                    chk_addr_val = cur_pc;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic redirect_to(input logic [AB-1:0] t);
        redir_ev_t e;
        e.ev_cyc = cyc;
        e.target = t;
        ev_q.push_back(e);
        redirect = 1'b1; redirect_pc = t;
        $display("redir cyc=%0d target=%h stall=%0b", cyc, t, ic_stall);
        tick();
        redirect = 1'b0;
    endtask

    task automatic wait_miss(input string name);
        int w = 0;
        @(negedge clk);
        while (!ic_stall && w < 10) begin
            @(negedge clk);
            w++;
        end
        check(name, 32'(ic_stall), 32'd1);
    endtask

    initial begin
        int            r;
        int            n;
        logic [AB-1:0] tgt;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_addr", 32'(icache_addr), 32'(RST_PC));
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_instr", instr, 32'd0);
        check("reset_instr_pc", 32'(instr_pc), 32'd0);
        check("reset_perf_stall", perf_stall, 32'd0);
        check("reset_perf_fetched", perf_fet, 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("addr_step", 32'(icache_addr), 32'(RST_PC) + 32'(4 * k));
            check("valid_latency", 32'(instr_valid), (k == 2) ? 32'd1 : 32'd0);
        end
        repeat (10) tick();

        // decode back-pressure: FIFO fills, fetch address holds two past the head
        dec_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 4) begin
                check("bp_valid", 32'(instr_valid), 32'd1);
                check("bp_addr_hold", 32'(icache_addr), 32'(cur_pc + 25'd8));
            end
        end
        tick();
        dec_ready = 1'b1;
        repeat (6) tick();

        // 20-cycle miss on 0x100, critical word in stall cycle 5
        force_addr = 25'h100; force_miss = 1;
        redirect_to(25'h100);
        wait_miss("miss_reached_0x100");
        n = 0;
        while (ic_stall && n < 30) begin
            check("addr_hold_in_miss", 32'(icache_addr), 32'h104);
            @(negedge clk);
            n++;
        end
        check("addr_stall_drop", 32'(icache_addr), 32'h104);
        repeat (10) tick();

        // redirect to 0x400 while the 0x100 miss is outstanding
        force_miss = 1;
        redirect_to(25'h100);
        wait_miss("miss2_reached_0x100");
        tick();
        redirect_to(25'h400);
        repeat (30) tick();

        redirect_to(25'h2003);
        repeat (10) tick();
        redirect_to(25'h1FF_FFF8);
        repeat (10) tick();

        // reset in the middle of a miss
        force_miss = 1;
        redirect_to(25'h100);
        wait_miss("miss3_reached_0x100");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();

        // randomized traffic
        miss_pct = 8;
        for (int i = 0; i < 2500; i++) begin
            dec_ready = ($urandom_range(0, 99) < 75);
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else if (r < 25) begin
                tgt = AB'($urandom);
                if ($urandom_range(0, 3) == 0) tgt = AB'($urandom_range(0, 63));
                redirect_to(tgt);
            end else begin
                tick();
            end
        end

        miss_pct = 0;
        dec_ready = 1'b1;
        repeat (30) tick();
        @(posedge clk); #2;
        check("final_perf_stall", perf_stall, PERF_EN ? 32'(stall_m) : 32'd0);
        check("final_perf_fetched", perf_fet, PERF_EN ? 32'(fet_m) : 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
